bcd_to_bin_seq: RTL and testbench

Parametrised, sequential BCD-to-binary converter for the alarm-clock datapath. It accepts a packed BCD word of DIGITS decimal digits with a start strobe and converts it one digit per clock, MSB digit first, using acc = acc*10 + digit. It returns the binary value with a one-cycle done pulse and flags any non-decimal nibble. It replaces the fixed 2-digit combinational converter wherever multi-digit values are needed: time-set entry, alarm compare and minute counters.

---
 rtl/bcd_to_bin_seq_pkg.sv | 9 +
 rtl/bcd_to_bin_seq_digit_mac.sv | 16 +
 rtl/bcd_to_bin_seq.sv | 81 ++++++++
 tb/tb_bcd_to_bin_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_to_bin_seq_pkg: shared FSM state and BCD constants for the BCD-to-binary converter
package bcd_to_bin_seq_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;
    localparam int         BCD_W         = 4;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
endpackage

// File: rtl/bcd_to_bin_seq_digit_mac.sv
// bcd_digit_mac: combinational acc*10+d step with non-decimal digit detect
// Ports: acc_i (W) running value, d_i (4) BCD digit, acc_o (W) acc_i*10+d_i truncated, bad_o digit > 9
module bcd_digit_mac
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int W = 7
) (
    input  logic [W-1:0]     acc_i,
    input  logic [BCD_W-1:0] d_i,
    output logic [W-1:0]     acc_o,
    output logic             bad_o
);
    // Shift-add form of *10, formed W+4 bits wide before truncation
    assign acc_o = W'(({4'b0, acc_i} << 3) + ({4'b0, acc_i} << 1) + {{W{1'b0}}, d_i});
    assign bad_o = d_i > BCD_DIGIT_MAX;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one digit per clock, MSB digit first
// Ports: clk, rst (sync, active-high), start/bcd request, busy while converting,
//        done one-cycle pulse, err non-decimal nibble seen, bin converted value
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int  DIGITS = 2,
    localparam int BIN_W  = $clog2(10**DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [BIN_W-1:0]        bin
);
    localparam int SR_W = BCD_W * DIGITS;
    localparam int CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e            state_q;
    logic [SR_W-1:0]   sr_q;
    logic [BIN_W-1:0]  acc_q, acc_d, bin_q;
    logic [CW-1:0]     cnt_q;
    logic              inv_q, busy_q, done_q, err_q;
    logic              bad_d, inv_d, last_d;

    bcd_digit_mac #(.W(BIN_W)) u_mac (
        .acc_i (acc_q),
        .d_i   (sr_q[SR_W-1 -: BCD_W]),
        .acc_o (acc_d),
        .bad_o (bad_d)
    );

    assign inv_d  = inv_q | bad_d;
    assign last_d = cnt_q == CW'(DIGITS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start) begin
                    sr_q    <= bcd;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    inv_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ST_CONV;
                end
            end else begin
                acc_q <= acc_d;
                inv_q <= inv_d;
                sr_q  <= sr_q << BCD_W;
                cnt_q <= cnt_q + CW'(1);
                if (last_d) begin
                    bin_q   <= inv_d ? '0 : acc_d;
                    err_q   <= inv_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign bin  = bin_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: checks DIGITS=1/2/4 converters cycle by cycle against a transaction-level model
module tb_bcd_to_bin_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        st[3];
    logic [15:0] bw[3];
    logic        b1, d1, e1, b2, d2, e2, b4, d4, e4;
    logic [3:0]  bin1;
    logic [6:0]  bin2;
    logic [13:0] bin4;
    logic        ob[3], od[3], oe[3];
    logic [31:0] obn[3];
    int          ncmp = 0;
    int          nerr = 0;
    int          nd[3] = '{1, 2, 4};
    logic        m_busy[3], m_done[3], m_err[3];
    int          m_bin[3], m_left[3];
    logic [15:0] m_w[3];

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .start(st[0]), .bcd(bw[0][3:0]),
        .busy(b1), .done(d1), .err(e1), .bin(bin1));
    bcd_to_bin_seq #(.DIGITS(2)) u2 (.clk(clk), .rst(rst), .start(st[1]), .bcd(bw[1][7:0]),
        .busy(b2), .done(d2), .err(e2), .bin(bin2));
    bcd_to_bin_seq #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .start(st[2]), .bcd(bw[2]),
        .busy(b4), .done(d4), .err(e4), .bin(bin4));

    assign ob[0] = b1;
    assign ob[1] = b2;
    assign ob[2] = b4;
    assign od[0] = d1;
    assign od[1] = d2;
    assign od[2] = d4;
    assign oe[0] = e1;
    assign oe[1] = e2;
    assign oe[2] = e4;
    assign obn[0] = 32'(bin1);
    assign obn[1] = 32'(bin2);
    assign obn[2] = 32'(bin4);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_conv(input logic [15:0] w, input int n, output int v, output logic e);
        int dig;
        v = 0;
        e = 1'b0;
        for (int k = 0; k < n; k++) begin
            dig = int'((w >> (4 * k)) & 16'hF);
            if (dig > 9) e = 1'b1;
            v += dig * (10 ** k);
        end
        if (e) v = 0;
    endfunction

    task automatic step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_err[i]  = 1'b0;
                m_bin[i]  = 0;
                m_left[i] = 0;
            end else begin
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (st[i]) begin
                        m_w[i]    = bw[i];
                        m_busy[i] = 1'b1;
                        m_left[i] = nd[i];
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        ref_conv(m_w[i], nd[i], m_bin[i], m_err[i]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("D%0d busy", nd[i]), 32'(ob[i]), 32'(m_busy[i]));
            chk($sformatf("D%0d done", nd[i]), 32'(od[i]), 32'(m_done[i]));
            chk($sformatf("D%0d err", nd[i]), 32'(oe[i]), 32'(m_err[i]));
            chk($sformatf("D%0d bin", nd[i]), obn[i], 32'(m_bin[i]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            w[4*k +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            bw[i] = 16'h0;
            m_w[i] = 16'h0;
        end
        repeat (2) step();
        rst = 1'b0;
        idle(1);
        st[0] = 1'b1; bw[0] = 16'h0007;
        st[1] = 1'b1; bw[1] = 16'h0015;
        st[2] = 1'b1; bw[2] = 16'h9999;
        step();
        idle(6);
        st[0] = 1'b1; bw[0] = 16'h000A;
        st[1] = 1'b1; bw[1] = 16'h0099;
        st[2] = 1'b1; bw[2] = 16'h0000;
        step();
        idle(6);
        st[1] = 1'b1; bw[1] = 16'h000F;
        step();
        idle(4);
        st[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bw[1] = c[0] ? 16'h0059 : 16'h0023;
            step();
        end
        idle(2);
        st[2] = 1'b1; bw[2] = 16'h1234;
        step();
        st[2] = 1'b0; bw[2] = 16'h5678;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);
        st[2] = 1'b1; bw[2] = 16'h0042;
        step();
        idle(5);
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                st[i] = ($urandom_range(0, 2) != 0);
                bw[i] = rnd_bcd();
            end
            rst = ($urandom_range(0, 70) == 0);
            step();
        end
        rst = 1'b0;
        idle(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
